led_write_queue: RTL and testbench

Memory-mapped write queue sitting directly upstream of the 8-bit LED output device. Absorbs CPU store bursts into a small FIFO and feeds one word at a time to the LED device over its `in_data`/`begin_flag`/`state_reg` handshake. Waits for the device's busy bit to clear before each issue, and exposes FIFO occupancy, busy and overflow to software as a 32-bit status word. The CPU therefore never stalls or polls per byte; it only checks `full`.

---
 rtl/led_queue_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/led_write_queue.sv | 115 +++++++++++
 tb/tb_led_write_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_queue_pkg.sv
// Shared types and constants for the LED write queue.
// FSM state encoding, status word bit map, device busy bit index.
package led_queue_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 5;

  localparam int DEV_BUSY = 0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth, head-of-queue data output.
// Ports: push/wdata in, pop in, full/empty/count/head out.
module sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              do_push;
  logic              do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rptr_q];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/led_write_queue.sv
// CPU store queue feeding the LED device one word per device cycle.
// Ports: wr_en/wr_data/clr_ovf from CPU, status to CPU, led_* to/from device.
module led_write_queue
  import led_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_ovf,
  output logic [31:0]       status,
  output logic [DATA_W-1:0] led_data,
  output logic              led_begin,
  input  logic [31:0]       led_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e            state_q;
  logic              led_begin_q;
  logic [DATA_W-1:0] led_data_q;
  logic [TW-1:0]     tmo_q;
  logic              ovf_q;
  logic              ovf_d;

  logic              dev_busy;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              unused_state;

  assign dev_busy     = led_state[DEV_BUSY];
  assign unused_state = ^led_state[31:1];

  // Head leaves the queue only once the device has finished with it.
  assign fifo_pop = (state_q == WAIT_DONE) && !dev_busy;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (wr_en),
    .wdata   (wr_data),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  // New overflow wins over a simultaneous clear.
  assign ovf_d = (ovf_q && !clr_ovf)
               || (wr_en && fifo_full && !fifo_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      led_begin_q <= 1'b0;
      led_data_q  <= '0;
      tmo_q       <= '0;
    end else begin
      led_begin_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty && !dev_busy) begin
            state_q     <= ISSUE;
            led_begin_q <= 1'b1;
            led_data_q  <= fifo_head;
          end
        end
        ISSUE: begin
          state_q <= WAIT_ACK;
          tmo_q   <= '0;
        end
        WAIT_ACK: begin
          if (dev_busy || tmo_q == TW'(ACK_TIMEOUT - 1))
            state_q <= WAIT_DONE;
          else
            tmo_q <= tmo_q + TW'(1);
        end
        WAIT_DONE: begin
          if (!dev_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign led_begin = led_begin_q;
  assign led_data  = led_data_q;

  always_comb begin
    status = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = (state_q != IDLE);
    status[ST_OVF]   = ovf_q;
    status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
  end

endmodule

// File: tb/tb_led_write_queue.sv
// Scoreboard bench for led_write_queue with a behavioural LED device.
// Device model: busy for dev_len cycles after each begin pulse.
module tb_led_write_queue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        clr_ovf = 1'b0;
  logic [31:0] status;
  logic [31:0] led_data;
  logic        led_begin;
  logic [31:0] led_state;

  logic        dev_busy = 1'b0;
  int          dev_cnt = 0;
  int          dev_len = 4;
  bit          dev_resp = 1'b1;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb [$];
  logic [31:0] issued = '0;
  bit          issued_ok = 1'b0;

  led_write_queue #(
    .DEPTH       (4),
    .DATA_W      (32),
    .ACK_TIMEOUT (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .status    (status),
    .led_data  (led_data),
    .led_begin (led_begin),
    .led_state (led_state)
  );

  always #5 clock = ~clock;

  assign led_state = {31'h05a5a5a5, dev_busy};

  always @(posedge clock) begin
    if (dev_cnt > 0) begin
      if (dev_cnt == 1) dev_busy <= 1'b0;
      dev_cnt <= dev_cnt - 1;
    end else if (led_begin && dev_resp) begin
      dev_busy <= 1'b1;
      dev_cnt  <= dev_len;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      issued_ok = 1'b0;
    end else if (led_begin) begin
      chk("begin_dev_idle", {31'b0, led_state[0]}, 32'h0);
      chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'h1);
      if (sb.size() != 0) chk("issue_data", led_data, sb.pop_front());
      issued    = led_data;
      issued_ok = 1'b1;
    end else if (issued_ok && led_state[0]) begin
      chk("data_stable", led_data, issued);
    end
  end

  task automatic wait_begin(input int budget, output int n);
    n = 0;
    while (!led_begin && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk("begin_seen", {31'b0, led_begin}, 32'h1);
  endtask

  task automatic wait_idle(input logic [31:0] exp, input int budget);
    int n = 0;
    while ((status !== exp || dev_busy) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_status", status, exp);
    chk("idle_dev", {31'b0, dev_busy}, 32'h0);
    chk("sb_drained", sb.size(), 32'h0);
  endtask

  initial begin
    int n;
    bit found;

    #1;
    chk("rst_status", status, 32'h2);
    chk("rst_begin", {31'b0, led_begin}, 32'h0);
    chk("rst_data", led_data, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // single word, long device cycle
    dev_len = 260;
    @(negedge clock);
    wr_en = 1'b1;
    wr_data = 32'h0000_00A5;
    sb.push_back(wr_data);
    @(posedge clock); #1;
    wr_en = 1'b0;
    chk("status_push1", status, 32'h0000_0010);
    n = 1;
    while (!led_begin && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("issue_latency", n, 32'd2);
    wait_idle(32'h2, 400);

    // burst of six into a busy device
    dev_len = 30;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      wr_en = 1'b1;
      wr_data = 32'h100 + i;
      if (i < 4) sb.push_back(wr_data);
    end
    @(negedge clock);
    wr_en = 1'b0;
    chk("burst_status", status, 32'h0000_004D);
    wait_idle(32'hA, 300);
    @(negedge clock);
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    chk("ovf_cleared", status, 32'h2);

    // push into full FIFO on the pop edge
    dev_len = 10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      wr_en = 1'b1;
      wr_data = 32'h200 + i;
      sb.push_back(wr_data);
    end
    @(negedge clock);
    wr_en = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (status[2] && !led_state[0] && !led_begin && status[8:4] == 5'd4)
        found = 1'b1;
      else
        @(negedge clock);
    end
    chk("pop_window", {31'b0, found}, 32'h1);
    wr_en = 1'b1;
    wr_data = 32'h300;
    sb.push_back(wr_data);
    @(posedge clock); #1;
    chk("full_pop_cnt", {27'b0, status[8:4]}, 32'd4);
    chk("full_pop_ovf", {31'b0, status[3]}, 32'h0);
    @(negedge clock);
    wr_en = 1'b0;
    wait_idle(32'h2, 300);

    // device never acknowledges
    dev_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      wr_en = 1'b1;
      wr_data = 32'h400 + i;
      sb.push_back(wr_data);
    end
    @(negedge clock);
    wr_en = 1'b0;
    wait_begin(20, n);
    @(posedge clock); #1;
    n = 1;
    while (!led_begin && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    chk("timeout_gap", n, 32'd7);
    wait_idle(32'h2, 50);
    dev_resp = 1'b1;

    // reset during WAIT_DONE, device keeps running
    dev_len = 40;
    @(negedge clock);
    wr_en = 1'b1;
    wr_data = 32'h55;
    sb.push_back(wr_data);
    @(negedge clock);
    wr_en = 1'b0;
    wait_begin(20, n);
    repeat (5) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_begin", {31'b0, led_begin}, 32'h0);
    chk("mid_rst_data", led_data, 32'h0);
    chk("mid_rst_status", status, 32'h2);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    wr_en = 1'b1;
    wr_data = 32'h77;
    sb.push_back(wr_data);
    @(negedge clock);
    wr_en = 1'b0;
    wait_begin(100, n);
    wait_idle(32'h2, 100);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
